issue_sched: RTL and testbench
==============================

# issue_sched

Scoreboard-based issue scheduler between the fetch/predecode front end and the execute/writeback pipe of the 32-bit NOP/ADD/MUL/ADDI core. It holds fetch on read-after-write (RAW) and write-after-write (WAW) hazards against results still in flight. While holding, it inserts NOP bubbles into the execute pipe. It also sequences run, drain and idle from the `start` level and reports when the pipe is empty.

## Interface
- `WIDTH`, 32, datapath width; passed through for consistency, no arithmetic on data.
- `LAT_ALU`, 2, cycles from ADD/ADDI issue to register-file write.
- `LAT_MUL`, 3, cycles from MUL issue to register-file write; must be ≥ `LAT_ALU` and ≤ 3.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; high = fetch/issue enabled.
- `opcode`  in  3  predecoded opcode: 000 NOP, 001 ADD, 010 MUL, 011 ADDI.
- `Rs1`, `Rs2`, `Rd`  in  5 each  predecoded register indices.
- `imm`  in  12  predecoded immediate, passed through.
- `stall`  out  1  combinational; high = the fetch PC holds and the current instruction is not consumed.
- `iss_opcode`  out  3  registered opcode to the execute pipe; NOP on a bubble.
- `iss_Rs1`, `iss_Rs2`, `iss_Rd`  out  5  registered.
- `iss_imm`  out  12  registered.
- `busy`  out  1  registered; high while state ≠ IDLE.
- `state`  out  2  00 IDLE, 01 RUN, 10 DRAIN.

## Operation
- **Scoreboard:** `sb[1..31]`, 2-bit countdown per register. `sb[0]` is hardwired 0, so x0 is never pending.
- **Sources used:**
  - ADD, MUL: `Rs1` and `Rs2`.
  - ADDI: `Rs1` only.
  - NOP: none.
- **RAW hazard:** any used source has `sb[src] ≠ 0`.
- **WAW hazard:** `Rd ≠ 0` and `sb[Rd] > lat(opcode)`, where `lat(opcode)` is the latency of the new instruction.
- **stall:** `= (state == RUN) & (RAW | WAW) & (opcode ≠ NOP)`.
- **Issue:** occurs at a rising edge when `state == RUN` and `stall == 0`.
  - `iss_*` capture the inputs.
  - If the opcode is not NOP and `Rd ≠ 0`: `sb[Rd] ← lat(opcode)`.
- **Bubble:** when `stall == 1`, or the state is not RUN, `iss_opcode ← 000` and the other `iss_*` fields ← 0.
- **Scoreboard decrement:** every edge, each nonzero entry decrements by 1.
  - On the same edge, a new issue to that register takes priority: it loads the new latency, with no decrement that cycle.
- **State machine (FSM):**
  - IDLE → RUN when `start == 1`.
  - RUN → DRAIN when `start == 0`.
  - DRAIN → IDLE when all `sb` entries are 0; DRAIN → RUN when `start == 1`.
  - In DRAIN, only the countdowns advance and only bubbles are issued.
- Out-of-range opcodes 100–111 are treated as NOP: never stalled, never scoreboarded.

## Timing
- **Reset (`rst == 0`, asynchronous):**
  - `sb` all 0, state IDLE, `busy = 0`.
  - `iss_opcode = 000`; `iss_Rs1/Rs2/Rd/imm = 0`.
  - `stall = 0`, since state is not RUN.
- Reset mid-operation discards all pending entries immediately. On release, the first RUN edge may issue without hazard checks against discarded work.
- **Issue latency:** one cycle from input to `iss_*`.
- **Dependent pair issued back-to-back:**
  - ALU producer → consumer: 2 stall cycles.
  - MUL producer → consumer: 3 stall cycles.
  - The consumer issues on the edge after the producer's entry reaches 0.
- **WAW:** MUL then ADD to the same `Rd` stalls the ADD 1 cycle (3 > 2 → 2 ≤ 2).
- **Simultaneous events:** if `start` falls in a cycle where `stall == 0`, that edge still issues, then the FSM enters DRAIN.
- The bubble on the stall edge is the only `iss_*` change during a stall; the held inputs must remain stable.

## Configuration
- **`ISSUE_SCHED_STATS_EN`** defined adds the following, all reset to 0 and saturating at 0xFFFF:
  - output `stall_cnt` [15:0]: edges in RUN with `stall == 1`.
  - output `issue_cnt` [15:0]: non-NOP issues.
- Undefined: the ports and the counters are absent; all other behaviour is identical.

## Test plan
- Reset with `start = 0` → `iss_opcode = 000`, `busy = 0`, `state = 00`, `stall = 0`; assert `rst` low mid-RUN → all outputs return to reset values without a clock edge.
- RUN with independent ADD x1, ADD x2, ADDI x3 → three consecutive issues, `stall` never high, `iss_Rd` = 1, 2, 3 on successive edges.
- `ADD x3 = x1 + x2` then `ADD x4 = x3 + x1` → `stall` high exactly 2 cycles, two bubbles, x4 issued on the 3rd edge after x3.
- `MUL x5` then `ADDI x6 = x5 + 7` → 3 stall cycles; `iss_imm = 7` on issue. `MUL x5` then `ADD x5` → 1 stall cycle (WAW).
- Dependence on x0 (`ADD x0` then `ADD x7 = x0 + x0`) → no stall.
- After `MUL x9`, drop `start` → DRAIN, `busy` stays high 2 more cycles and returns to IDLE when `sb[9] = 0`. With `ISSUE_SCHED_STATS_EN`, `issue_cnt` and `stall_cnt` match the counts above.

Source files
------------

// File: rtl/issue_sched_if.sv
// ============================================================================
// issue_sched_if : front-end inputs and execute-pipe outputs of issue_sched
// Optional stats ports: ISSUE_SCHED_STATS_EN         Rev 1.0
// ============================================================================
`default_nettype none

interface issue_sched_if;
   logic        start;
   logic [2:0]  opcode;
   logic [4:0]  Rs1;
   logic [4:0]  Rs2;
   logic [4:0]  Rd;
   logic [11:0] imm;
   logic        stall;
   logic [2:0]  iss_opcode;
   logic [4:0]  iss_Rs1;
   logic [4:0]  iss_Rs2;
   logic [4:0]  iss_Rd;
   logic [11:0] iss_imm;
   logic        busy;
   logic [1:0]  state;
`ifdef ISSUE_SCHED_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] issue_cnt;
`endif

   modport master (
      output start, opcode, Rs1, Rs2, Rd, imm,
`ifdef ISSUE_SCHED_STATS_EN
      input  stall_cnt, issue_cnt,
`endif
      input  stall, iss_opcode, iss_Rs1, iss_Rs2, iss_Rd, iss_imm, busy, state
   );

   modport slave (
      input  start, opcode, Rs1, Rs2, Rd, imm,
`ifdef ISSUE_SCHED_STATS_EN
      output stall_cnt, issue_cnt,
`endif
      output stall, iss_opcode, iss_Rs1, iss_Rs2, iss_Rd, iss_imm, busy, state
   );
endinterface

`default_nettype wire

// File: rtl/issue_sched.sv
// ============================================================================
// issue_sched : scoreboard issue scheduler with RAW/WAW hold and run/drain FSM
// Optional stall/issue counters: ISSUE_SCHED_STATS_EN  Rev 1.0
// ============================================================================
`default_nettype none

module issue_sched #(
   parameter int WIDTH   = 32,
   parameter int LAT_ALU = 2,
   parameter int LAT_MUL = 3
) (
   input  logic         clk,
   input  logic         rst,
   issue_sched_if.slave bus
);
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [1:0] LAT_A   = 2'(LAT_ALU);
   localparam logic [1:0] LAT_M   = 2'(LAT_MUL);

   generate
      if (WIDTH < 1 || LAT_ALU < 1 || LAT_MUL < LAT_ALU || LAT_MUL > 3) begin : g_param_check
         $error("issue_sched: invalid WIDTH/LAT_ALU/LAT_MUL");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_t;

   state_t     state;
   logic [1:0] sb [0:31];

   logic       is_mul, is_valid, use_rs2;
   logic [1:0] lat;
   logic       raw, waw, stall, do_issue, all_clear;

   always_comb begin
      is_mul    = (bus.opcode == OP_MUL);
      is_valid  = (bus.opcode == OP_ADD) || is_mul || (bus.opcode == OP_ADDI);
      use_rs2   = (bus.opcode == OP_ADD) || is_mul;
      lat       = is_mul ? LAT_M : LAT_A;
      // sb[0] is never loaded, so x0 never reports pending
      raw       = is_valid && ((sb[bus.Rs1] != 2'd0) || (use_rs2 && (sb[bus.Rs2] != 2'd0)));
      waw       = is_valid && (bus.Rd != 5'd0) && (sb[bus.Rd] > lat);
      stall     = (state == RUN) && (raw || waw);
      do_issue  = (state == RUN) && !stall;
      all_clear = 1'b1;
      for (int i = 1; i < 32; i++) begin
         if (sb[i] != 2'd0) all_clear = 1'b0;
      end
   end

   assign bus.stall = stall;
   assign bus.state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) sb[i] <= 2'd0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (do_issue && is_valid && (bus.Rd == 5'(i))) sb[i] <= lat;
            else if (sb[i] != 2'd0)                         sb[i] <= sb[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         bus.busy       <= 1'b0;
         bus.iss_opcode <= OP_NOP;
         bus.iss_Rs1    <= 5'd0;
         bus.iss_Rs2    <= 5'd0;
         bus.iss_Rd     <= 5'd0;
         bus.iss_imm    <= 12'd0;
      end else begin
         if (do_issue) begin
            bus.iss_opcode <= bus.opcode;
            bus.iss_Rs1    <= bus.Rs1;
            bus.iss_Rs2    <= bus.Rs2;
            bus.iss_Rd     <= bus.Rd;
            bus.iss_imm    <= bus.imm;
         end else begin
            bus.iss_opcode <= OP_NOP;
            bus.iss_Rs1    <= 5'd0;
            bus.iss_Rs2    <= 5'd0;
            bus.iss_Rd     <= 5'd0;
            bus.iss_imm    <= 12'd0;
         end
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               if (!bus.start) state <= DRAIN;
               bus.busy <= 1'b1;
            end
            DRAIN: begin
               // a returning start wins over an empty scoreboard
               if (bus.start) begin
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end else if (all_clear) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef ISSUE_SCHED_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.stall_cnt <= 16'd0;
         bus.issue_cnt <= 16'd0;
      end else begin
         if (stall && (bus.stall_cnt != 16'hFFFF))
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
         if (do_issue && is_valid && (bus.issue_cnt != 16'hFFFF))
            bus.issue_cnt <= bus.issue_cnt + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_sched.sv
// ============================================================================
// tb_issue_sched : directed self-checking bench for issue_sched   Rev 1.0
// ============================================================================
`default_nettype none

module tb_issue_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   issue_sched_if bus ();

   issue_sched #(.WIDTH(32), .LAT_ALU(2), .LAT_MUL(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [11:0] im);
      bus.opcode = op;
      bus.Rs1    = r1;
      bus.Rs2    = r2;
      bus.Rd     = rd;
      bus.imm    = im;
      #1;
   endtask

   task automatic chk_issue(input string tag, input logic [2:0] op, input logic [4:0] rd);
      chk({tag, "_op"}, 32'(bus.iss_opcode), 32'(op));
      chk({tag, "_rd"}, 32'(bus.iss_Rd), 32'(rd));
   endtask

   initial begin
      bus.start = 1'b0;
      drive(3'd0, 5'd0, 5'd0, 5'd0, 12'd0);
      #1 rst = 1'b0;
      tick();
      tick();
      chk("rst_iss_op", 32'(bus.iss_opcode), 32'd0);
      chk("rst_busy",   32'(bus.busy), 32'd0);
      chk("rst_state",  32'(bus.state), 32'd0);
      chk("rst_stall",  32'(bus.stall), 32'd0);
      rst = 1'b1;

      // independent ADD x1, ADD x2, ADDI x3
      bus.start = 1'b1;
      drive(3'd1, 5'd10, 5'd11, 5'd1, 12'd0);
      tick();
      chk("enter_run", 32'(bus.state), 32'd1);
      chk("run_busy",  32'(bus.busy), 32'd1);
      chk("ind1_stall", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("ind1", 3'd1, 5'd1);
      drive(3'd1, 5'd10, 5'd11, 5'd2, 12'd0);
      chk("ind2_stall", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("ind2", 3'd1, 5'd2);
      drive(3'd3, 5'd12, 5'd0, 5'd3, 12'd5);
      chk("ind3_stall", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("ind3", 3'd3, 5'd3);
      chk("ind3_imm", 32'(bus.iss_imm), 32'd5);

      drive(3'd0, 5'd0, 5'd0, 5'd0, 12'd0);
      tick();
      chk_issue("nop1", 3'd0, 5'd0);
      tick();

      // ALU RAW: ADD x3 = x1 + x2 ; ADD x4 = x3 + x1
      drive(3'd1, 5'd1, 5'd2, 5'd3, 12'd0);
      chk("raw_a_stall0", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("raw_a_prod", 3'd1, 5'd3);
      drive(3'd1, 5'd3, 5'd1, 5'd4, 12'd0);
      chk("raw_a_stall1", 32'(bus.stall), 32'd1);
      tick();
      chk_issue("raw_a_bub1", 3'd0, 5'd0);
      chk("raw_a_stall2", 32'(bus.stall), 32'd1);
      tick();
      chk_issue("raw_a_bub2", 3'd0, 5'd0);
      chk("raw_a_stall3", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("raw_a_cons", 3'd1, 5'd4);

      // MUL RAW: MUL x5 ; ADDI x6 = x5 + 7
      drive(3'd2, 5'd10, 5'd11, 5'd5, 12'd0);
      chk("raw_m_stall0", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("raw_m_prod", 3'd2, 5'd5);
      drive(3'd3, 5'd5, 5'd0, 5'd6, 12'd7);
      chk("raw_m_stall1", 32'(bus.stall), 32'd1);
      tick();
      chk_issue("raw_m_bub1", 3'd0, 5'd0);
      chk("raw_m_stall2", 32'(bus.stall), 32'd1);
      tick();
      chk("raw_m_stall3", 32'(bus.stall), 32'd1);
      tick();
      chk_issue("raw_m_bub3", 3'd0, 5'd0);
      chk("raw_m_stall4", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("raw_m_cons", 3'd3, 5'd6);
      chk("raw_m_imm", 32'(bus.iss_imm), 32'd7);

      // WAW: MUL x5 ; ADD x5
      drive(3'd2, 5'd10, 5'd11, 5'd5, 12'd0);
      chk("waw_stall0", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("waw_prod", 3'd2, 5'd5);
      drive(3'd1, 5'd10, 5'd11, 5'd5, 12'd0);
      chk("waw_stall1", 32'(bus.stall), 32'd1);
      tick();
      chk_issue("waw_bub", 3'd0, 5'd0);
      chk("waw_stall2", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("waw_cons", 3'd1, 5'd5);

      // x0 never pending
      drive(3'd1, 5'd10, 5'd11, 5'd0, 12'd0);
      chk("x0_stall0", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("x0_prod", 3'd1, 5'd0);
      drive(3'd1, 5'd0, 5'd0, 5'd7, 12'd0);
      chk("x0_stall1", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("x0_cons", 3'd1, 5'd7);

      // MUL x9 issued on the edge where start falls, then drain
      drive(3'd2, 5'd10, 5'd11, 5'd9, 12'd0);
      bus.start = 1'b0;
      #1;
      chk("drain_stall", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("drain_mul", 3'd2, 5'd9);
      chk("drain_state0", 32'(bus.state), 32'd2);
      drive(3'd0, 5'd0, 5'd0, 5'd0, 12'd0);
      tick();
      chk_issue("drain_bub", 3'd0, 5'd0);
      chk("drain_state1", 32'(bus.state), 32'd2);
      chk("drain_busy1",  32'(bus.busy), 32'd1);
      tick();
      chk("drain_busy2",  32'(bus.busy), 32'd1);
      tick();
      chk("drain_state3", 32'(bus.state), 32'd2);
      tick();
      chk("drain_idle",   32'(bus.state), 32'd0);
      chk("drain_busy4",  32'(bus.busy), 32'd0);

`ifdef ISSUE_SCHED_STATS_EN
      chk("issue_cnt", 32'(bus.issue_cnt), 32'd12);
      chk("stall_cnt", 32'(bus.stall_cnt), 32'd6);
`endif

      // asynchronous reset mid-RUN with a MUL in flight
      bus.start = 1'b1;
      drive(3'd2, 5'd10, 5'd11, 5'd8, 12'h3a);
      tick();
      tick();
      chk_issue("mid_mul", 3'd2, 5'd8);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_op",    32'(bus.iss_opcode), 32'd0);
      chk("mid_rst_imm",   32'(bus.iss_imm), 32'd0);
      chk("mid_rst_busy",  32'(bus.busy), 32'd0);
      chk("mid_rst_state", 32'(bus.state), 32'd0);
      chk("mid_rst_stall", 32'(bus.stall), 32'd0);
      rst = 1'b1;
      drive(3'd1, 5'd8, 5'd8, 5'd10, 12'd0);
      tick();
      chk("post_rst_run",   32'(bus.state), 32'd1);
      chk("post_rst_stall", 32'(bus.stall), 32'd0);
      tick();
      chk_issue("post_rst", 3'd1, 5'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
